dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised data memory for the single-cycle RV32I core. Replaces the fixed 64K-word array.
- Takes byte addresses and handles RV32I load/store sizes.
- Merges true byte lanes on stores and sign/zero-extends loads.
- Flags misaligned accesses.
- After reset, clears the array with a sequential sweep instead of a one-shot reset of every entry, so it maps to block RAM.

Parameters:
- ADDR_W, 16: byte-address width. Word depth is DEPTH = 2**(ADDR_W-2).
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = skip the sweep (contents undefined).

Ports:
- i_clk, in, 1: clock.
- i_reset, in, 1: reset, asynchronous, active-low.
- i_req, in, 1: access request, qualified by o_ready.
- i_we, in, 1: 1 = store, 0 = load.
- i_addr, in, ADDR_W: byte address.
- i_size, in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- i_unsigned, in, 1: load zero-extend (LBU/LHU); ignored for stores.
- i_wdata, in, 32: store data, LSB-justified.
- o_ready, out, 1: memory idle and accepting requests.
- o_busy, out, 1: clear sweep in progress.
- o_rvalid, out, 1: load response valid, one-cycle pulse.
- o_rdata, out, 32: extended load data.
- o_misalign, out, 1: fault pulse aligned to the response cycle.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=CLEAR, or IDLE if CLEAR_ON_RESET=0; clr_cnt=0.
  - o_ready=0 (1 if CLEAR_ON_RESET=0); o_busy=CLEAR_ON_RESET.
  - o_rvalid=0, o_rdata=0, o_misalign=0.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each clock writes 0 to mem[clr_cnt], then clr_cnt++.
  - When clr_cnt==DEPTH-1 is written, go to IDLE. Sweep length is exactly DEPTH cycles.
  - i_req is ignored; o_ready=0, o_busy=1.
- IDLE:
  - o_ready=1, o_busy=0. A request is accepted when i_req && o_ready; at most one per cycle.
- Addressing:
  - word index = i_addr[ADDR_W-1:2]; lane = i_addr[1:0].
  - Every address is in range by construction.
- Misalignment:
  - Misaligned if: half with lane[0]=1; word with lane!=0; or i_size=11.
  - A misaligned access performs no write and no array state change.
- Store, aligned, written at the accepting clock edge:
  - byte: byte enable = 1<<lane; i_wdata[7:0] replicated to all lanes.
  - half: byte enable = 0011<<lane; i_wdata[15:0] replicated to both halves.
  - word: byte enable = 1111.
  - Unenabled bytes keep their old value (read-modify-write is not allowed; use per-byte write enables).
- Load:
  - Synchronous read with 1-cycle latency: o_rvalid=1 in the cycle after acceptance.
  - o_rdata takes the selected byte/half, sign-extended from bit 7/15, or zero-extended if i_unsigned=1.
  - Word loads pass through unchanged.
  - Misaligned load: o_rvalid=1, o_rdata=0, o_misalign=1.
- Misaligned store: no write; o_misalign=1 in the next cycle; o_rvalid stays 0.
- Non-response cycles: o_rvalid=0 and o_misalign=0. o_rdata holds its last value.
- Store followed by load to the same word in the next cycle: the load returns the new data. There is no same-cycle collision (single port).
- Reset asserted mid-sweep or mid-response:
  - Immediate return to the reset values; a pending response is dropped.
  - The sweep restarts from 0.

Decomposition:
- Package dmem_pkg:
  - typedef enum mem_size_e {SZ_B, SZ_H, SZ_W, SZ_ILL}.
  - typedef enum dmem_state_e {CLEAR, IDLE}.
  - Function is_misaligned(size, lane).
  - Constant WORD_BYTES=4.
- Sub-module dmem_lane_align (combinational): computes store byte enables and replicated data, and load lane select and extension. It is shared with the future cache fill path.
- Top level holds the FSM, clear counter, array and response registers.

Test Plan (ADDR_W=8, DEPTH=64):
- Reset release with CLEAR_ON_RESET=1 -> o_busy=1 and o_ready=0 for exactly 64 cycles, then o_ready=1; load of word 0x3C returns 0, and a req held high during the sweep causes no write.
- Word store 0xDEADBEEF @0x10, then SB 0x5A @0x12 -> LW @0x10 returns 0xDE5ABEEF one cycle after accept.
- LB @0x13 on 0xDE5ABEEF -> 0xFFFFFFDE; LBU -> 0x000000DE; LH @0x12 -> 0xFFFFDE5A; LHU -> 0x0000DE5A.
- SW @0x11 and SH @0x13 -> o_misalign=1 next cycle, word 0x10 still reads 0xDE5ABEEF; LW @0x12 -> o_rvalid=1, o_rdata=0, o_misalign=1.
- i_size=11 load @0x20 -> o_misalign=1, o_rdata=0.
- i_reset pulsed low at sweep cycle 30 -> o_busy stays 1 and the sweep restarts, giving 64 more cycles. i_reset pulsed during a load response -> o_rvalid=0 immediately.
- Back-to-back SW 0x11223344 @0x04 then LW @0x04 on consecutive cycles -> load returns 0x11223344.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32I data memory and its lane alignment logic.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } mem_size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dmem_state_e;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core load/store path and the data memory.
interface dmem_lsu_if #(
  parameter int ADDR_W = 16
) ();

  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [31:0]       i_wdata;
  logic              o_ready;
  logic              o_busy;
  logic              o_rvalid;
  logic [31:0]       o_rdata;
  logic              o_misalign;

  modport master (
    output i_req, i_we, i_addr, i_size, i_unsigned, i_wdata,
    input  o_ready, o_busy, o_rvalid, o_rdata, o_misalign
  );

  modport slave (
    input  i_req, i_we, i_addr, i_size, i_unsigned, i_wdata,
    output o_ready, o_busy, o_rvalid, o_rdata, o_misalign
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and load lane select with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  mem_size_e   i_st_size,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_data,
  input  mem_size_e   i_ld_size,
  input  logic [1:0]  i_ld_lane,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be   = '0;
    o_st_data = i_st_data;
    case (i_st_size)
      SZ_B: begin
        o_st_be   = 4'b0001 << i_st_lane;
        o_st_data = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        o_st_be   = 4'b0011 << i_st_lane;
        o_st_data = {2{i_st_data[15:0]}};
      end
      SZ_W:    o_st_be = 4'b1111;
      default: o_st_be = '0;
    endcase
  end

  always_comb begin
    case (i_ld_lane)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_ld_lane[1] ? i_ld_word[31:16] : i_ld_word[15:0];
  end

  always_comb begin
    o_ld_data = '0;
    case (i_ld_size)
      SZ_B:    o_ld_data = i_ld_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_ld_data = i_ld_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      SZ_W:    o_ld_data = i_ld_word;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Parametrised RV32I data memory: byte-lane stores, extended loads, misalign flags, post-reset clear sweep.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_reset,
  dmem_lsu_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
  localparam int unsigned IDX_W = ADDR_W - 2;

  logic [WORD_BYTES-1:0][7:0] r_mem [DEPTH];

  dmem_state_e          r_state;
  dmem_state_e          w_next;
  logic [IDX_W-1:0]     r_clr_cnt;
  logic                 w_ready;
  logic                 w_busy;

  logic                 w_accept;
  logic                 w_mis;
  logic [IDX_W-1:0]     w_idx;
  logic [1:0]           w_lane;
  mem_size_e            w_size;
  logic [3:0]           w_st_be;
  logic [31:0]          w_st_data;

  logic [3:0]           w_wr_be;
  logic [IDX_W-1:0]     w_wr_idx;
  logic [3:0][7:0]      w_wr_data;

  logic [31:0]          r_rd_word;
  mem_size_e            r_ld_size;
  logic [1:0]           r_ld_lane;
  logic                 r_ld_uns;
  logic                 r_have_data;
  logic                 r_rvalid;
  logic                 r_misalign;
  logic [31:0]          w_ld_data;

  // FSM: state register, next state, outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == CLEAR && r_clr_cnt == '1) w_next = IDLE;
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      CLEAR:   w_busy  = 1'b1;
      IDLE:    w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_accept = bus.i_req & w_ready;
  assign w_idx    = bus.i_addr[ADDR_W-1:2];
  assign w_lane   = bus.i_addr[1:0];
  assign w_size   = mem_size_e'(bus.i_size);
  assign w_mis    = is_misaligned(w_size, w_lane);

  dmem_lane_align u_align (
    .i_st_size     (w_size),
    .i_st_lane     (w_lane),
    .i_st_data     (bus.i_wdata),
    .o_st_be       (w_st_be),
    .o_st_data     (w_st_data),
    .i_ld_size     (r_ld_size),
    .i_ld_lane     (r_ld_lane),
    .i_ld_unsigned (r_ld_uns),
    .i_ld_word     (r_rd_word),
    .o_ld_data     (w_ld_data)
  );

  // Single write port shared by the clear sweep and aligned stores.
  always_comb begin
    w_wr_be   = '0;
    w_wr_idx  = w_idx;
    w_wr_data = w_st_data;
    if (r_state == CLEAR) begin
      w_wr_be   = '1;
      w_wr_idx  = r_clr_cnt;
      w_wr_data = '0;
    end else if (w_accept && bus.i_we && !w_mis) begin
      w_wr_be = w_st_be;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (w_wr_be[b]) r_mem[w_wr_idx][b] <= w_wr_data[b];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && !bus.i_we && !w_mis) r_rd_word <= r_mem[w_idx];
  end

  // Read word register has no reset so it maps to the RAM output; r_have_data masks it instead.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rvalid    <= 1'b0;
      r_misalign  <= 1'b0;
      r_have_data <= 1'b0;
      r_ld_size   <= SZ_W;
      r_ld_lane   <= '0;
      r_ld_uns    <= 1'b0;
    end else begin
      r_rvalid   <= w_accept & ~bus.i_we;
      r_misalign <= w_accept & w_mis;
      if (w_accept && !bus.i_we) begin
        r_have_data <= ~w_mis;
        r_ld_size   <= w_size;
        r_ld_lane   <= w_lane;
        r_ld_uns    <= bus.i_unsigned;
      end
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_busy     = w_busy;
  assign bus.o_rvalid   = r_rvalid;
  assign bus.o_misalign = r_misalign;
  assign bus.o_rdata    = r_have_data ? w_ld_data : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with ADDR_W=8 (64 words): directed stores/loads, misalign, reset sweeps.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(8)) bus ();

  dmem_lsu #(.ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        rvalid;
    logic        mis;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response cycle pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.o_rvalid || bus.o_misalign)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp: got rvalid=%0b misalign=%0b rdata=0x%08h expected no response",
                 bus.o_rvalid, bus.o_misalign, bus.o_rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.o_rvalid !== e.rvalid || bus.o_misalign !== e.mis ||
            (e.rvalid && bus.o_rdata !== e.rdata)) begin
          failures++;
          $display("FAIL %s: got rvalid=%0b misalign=%0b rdata=0x%08h expected rvalid=%0b misalign=%0b rdata=0x%08h",
                   e.tag, bus.o_rvalid, bus.o_misalign, bus.o_rdata, e.rvalid, e.mis, e.rdata);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [7:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       input logic ev, input logic emis, input logic [31:0] erd, input string tag);
    exp_t e;
    bus.i_req      = 1'b1;
    bus.i_we       = we;
    bus.i_addr     = addr;
    bus.i_size     = size;
    bus.i_unsigned = uns;
    bus.i_wdata    = wd;
    if (ev || emis) begin
      e.rvalid = ev;
      e.mis    = emis;
      e.rdata  = erd;
      e.tag    = tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
  endtask

  task automatic ld(input logic [7:0] a, input logic [1:0] s, input logic u,
                    input logic [31:0] exp, input string tag);
    issue(1'b0, a, s, u, 32'h0, 1'b1, 1'b0, exp, tag);
  endtask

  task automatic ld_mis(input logic [7:0] a, input logic [1:0] s, input string tag);
    issue(1'b0, a, s, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, tag);
  endtask

  task automatic st(input logic [7:0] a, input logic [1:0] s, input logic [31:0] wd);
    issue(1'b1, a, s, 1'b0, wd, 1'b0, 1'b0, 32'h0, "store");
  endtask

  task automatic st_mis(input logic [7:0] a, input logic [1:0] s, input logic [31:0] wd, input string tag);
    issue(1'b1, a, s, 1'b0, wd, 1'b0, 1'b1, 32'h0, tag);
  endtask

  // Counts negedges with busy=1/ready=0; optionally drops i_req after drop_at cycles.
  task automatic measure_sweep(output int n, input int drop_at);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_busy && !bus.o_ready) n++;
      else break;
      if (n == drop_at) bus.i_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.i_req      = 1'b0;
    bus.i_we       = 1'b0;
    bus.i_addr     = '0;
    bus.i_size     = 2'b10;
    bus.i_unsigned = 1'b0;
    bus.i_wdata    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready",    {31'd0, bus.o_ready},    32'd0);
    chk("reset_busy",     {31'd0, bus.o_busy},     32'd1);
    chk("reset_rvalid",   {31'd0, bus.o_rvalid},   32'd0);
    chk("reset_misalign", {31'd0, bus.o_misalign}, 32'd0);
    chk("reset_rdata",    bus.o_rdata,             32'd0);

    // A store request held through most of the sweep must be ignored.
    bus.i_req   = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_addr  = 8'h3C;
    bus.i_size  = 2'b10;
    bus.i_wdata = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    measure_sweep(n, 50);
    chk("sweep_len",         n,                    32'd64);
    chk("ready_after_sweep", {31'd0, bus.o_ready}, 32'd1);
    chk("busy_after_sweep",  {31'd0, bus.o_busy},  32'd0);
    bus.i_we = 1'b0;
    #1;

    ld(8'h3C, 2'b10, 1'b0, 32'h0000_0000, "lw_3c_cleared");

    st(8'h10, 2'b10, 32'hDEAD_BEEF);
    st(8'h12, 2'b00, 32'h0000_005A);
    ld(8'h10, 2'b10, 1'b0, 32'hDE5A_BEEF, "lw_10_merged");
    ld(8'h13, 2'b00, 1'b0, 32'hFFFF_FFDE, "lb_13");
    ld(8'h13, 2'b00, 1'b1, 32'h0000_00DE, "lbu_13");
    ld(8'h12, 2'b01, 1'b0, 32'hFFFF_DE5A, "lh_12");
    ld(8'h12, 2'b01, 1'b1, 32'h0000_DE5A, "lhu_12");
    ld(8'h10, 2'b00, 1'b0, 32'hFFFF_FFEF, "lb_10");
    ld(8'h11, 2'b00, 1'b1, 32'h0000_00BE, "lbu_11");
    ld(8'h10, 2'b01, 1'b0, 32'hFFFF_BEEF, "lh_10");

    st_mis(8'h11, 2'b10, 32'h1111_1111, "sw_11_mis");
    st_mis(8'h13, 2'b01, 32'h2222_2222, "sh_13_mis");
    st_mis(8'h10, 2'b11, 32'h3333_3333, "sill_10_mis");
    ld(8'h10, 2'b10, 1'b0, 32'hDE5A_BEEF, "lw_10_after_mis");
    ld_mis(8'h12, 2'b10, "lw_12_mis");
    ld_mis(8'h20, 2'b11, "lill_20_mis");

    st(8'h16, 2'b01, 32'h1234_ABCD);
    ld(8'h14, 2'b10, 1'b0, 32'hABCD_0000, "lw_14_half_hi");
    ld(8'h16, 2'b01, 1'b0, 32'hFFFF_ABCD, "lh_16");

    st(8'h04, 2'b10, 32'h1122_3344);
    ld(8'h04, 2'b10, 1'b0, 32'h1122_3344, "lw_04_b2b");
    st(8'h05, 2'b00, 32'h0000_0077);
    ld(8'h04, 2'b10, 1'b0, 32'h1122_7744, "lw_04_b2b_byte");

    repeat (3) @(posedge clk);
    #1;
    chk("rdata_hold",  bus.o_rdata,            32'h1122_7744);
    chk("idle_rvalid", {31'd0, bus.o_rvalid},  32'd0);

    // Reset landing on a load response drops it at once.
    bus.i_req  = 1'b1;
    bus.i_we   = 1'b0;
    bus.i_addr = 8'h04;
    bus.i_size = 2'b10;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    chk("rvalid_before_reset", {31'd0, bus.o_rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rvalid_reset_drop", {31'd0, bus.o_rvalid}, 32'd0);
    chk("rdata_reset_drop",  bus.o_rdata,           32'd0);
    chk("busy_reset_drop",   {31'd0, bus.o_busy},   32'd1);
    chk("ready_reset_drop",  {31'd0, bus.o_ready},  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset pulse 30 cycles into the sweep restarts it from zero.
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("busy_mid_sweep_reset",  {31'd0, bus.o_busy},  32'd1);
    chk("ready_mid_sweep_reset", {31'd0, bus.o_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_sweep(n, -1);
    chk("sweep_len_restart", n,                    32'd64);
    chk("ready_after_restart", {31'd0, bus.o_ready}, 32'd1);
    #1;

    ld(8'h04, 2'b10, 1'b0, 32'h0000_0000, "lw_04_recleared");
    ld(8'h10, 2'b10, 1'b0, 32'h0000_0000, "lw_10_recleared");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
